// File: rtl/modinv_pkg.sv
// Shared types and constants for the modular-inverse unit.
// The optional MODINV_STATS_EN build adds an iteration-count output to mod_inverse.
package modinv_pkg;

  localparam int MODINV_WIDTH = 16;
  localparam int ITER_CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_REDUCE = 3'd2,
    S_DIVIDE = 3'd3,
    S_UPDATE = 3'd4,
    S_FINAL  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ITER_CNT_W-1:0] sat_inc(input logic [ITER_CNT_W-1:0] v);
    logic [ITER_CNT_W-1:0] one;
    one = {{(ITER_CNT_W-1){1'b0}}, 1'b1};
    if (v == {ITER_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + one;
    end
  endfunction

endpackage

// File: rtl/mod_inverse_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per cycle,
// done pulses exactly WIDTH cycles after start; divide-by-zero yields q=all-ones, rem=dividend.
module mod_divider
  import modinv_pkg::*;
#(
  parameter int WIDTH = MODINV_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             done_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [CW-1:0]      r_cnt;
  logic               r_dz;
  logic               r_done;
  logic [2*WIDTH-1:0] w_step_first;
  logic [2*WIDTH-1:0] w_step;

  // r_quo starts as the dividend and collects quotient bits from the LSB as dividend bits leave the MSB.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_n;
    logic             bit_n;
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) begin
      rem_n = diff[WIDTH-1:0];
      bit_n = 1'b1;
    end else begin
      rem_n = trial[WIDTH-1:0];
      bit_n = 1'b0;
    end
    return {rem_n, quo[WIDTH-2:0], bit_n};
  endfunction

  assign w_step_first = div_step({WIDTH{1'b0}}, dividend_in, divisor_in);
  assign w_step       = div_step(r_rem, r_quo, r_div);

  // The first step happens on the start edge, so the last of WIDTH steps lands WIDTH-1 edges later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rem  <= {WIDTH{1'b0}};
      r_quo  <= {WIDTH{1'b0}};
      r_div  <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_dz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_in) begin
        r_div  <= divisor_in;
        r_cnt  <= CW'(WIDTH - 1);
        r_done <= (WIDTH == 1);
        if (divisor_in == {WIDTH{1'b0}}) begin
          r_dz  <= 1'b1;
          r_quo <= {WIDTH{1'b1}};
          r_rem <= dividend_in;
        end else begin
          r_dz           <= 1'b0;
          {r_rem, r_quo} <= w_step_first;
        end
      end else if (r_cnt != {CW{1'b0}}) begin
        r_cnt  <= r_cnt - CW'(1);
        r_done <= (r_cnt == CW'(1));
        if (!r_dz) begin
          {r_rem, r_quo} <= w_step;
        end
      end
    end
  end

  assign quotient_out  = r_quo;
  assign remainder_out = r_rem;
  assign done_out      = r_done;

endmodule

// File: rtl/mod_inverse.sv
// Sequential modular inverse d = a^-1 mod m by iterative extended Euclid.
// Define MODINV_STATS_EN to add iter_count_out (DIVIDE iterations of the last result).
module mod_inverse
  import modinv_pkg::*;
#(
  parameter int WIDTH = MODINV_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             exists_out,
  output logic             busy_out,
  output logic             valid_out
`ifdef MODINV_STATS_EN
  ,
  output logic [ITER_CNT_W-1:0] iter_count_out
`endif
);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_m;
  logic [WIDTH-1:0]      r_r0;
  logic [WIDTH-1:0]      r_r1;
  logic signed [WIDTH:0] r_t0;
  logic signed [WIDTH:0] r_t1;
  logic                  r_launched;
  logic [WIDTH-1:0]      r_res;
  logic                  r_exists;
  logic [WIDTH-1:0]      r_value;
  logic                  r_exists_out;
  logic                  r_busy;
  logic                  r_valid;
`ifdef MODINV_STATS_EN
  logic [ITER_CNT_W-1:0] r_iter;
  logic [ITER_CNT_W-1:0] r_iter_out;
`endif

  logic                    w_div_start;
  logic [WIDTH-1:0]        w_div_dividend;
  logic [WIDTH-1:0]        w_div_divisor;
  logic [WIDTH-1:0]        w_div_q;
  logic [WIDTH-1:0]        w_div_r;
  logic                    w_div_done;
  logic                    w_m_small;
  logic signed [2*WIDTH:0] w_q_ext;
  logic signed [2*WIDTH:0] w_t0_ext;
  logic signed [2*WIDTH:0] w_t1_ext;
  logic signed [2*WIDTH:0] w_prod;
  logic signed [2*WIDTH:0] w_tdiff;
  logic signed [WIDTH:0]   w_t_new;
  logic signed [WIDTH:0]   w_t0_adj;

  assign w_m_small = (r_m[WIDTH-1:1] == {(WIDTH-1){1'b0}});

  // REDUCE launches a / m; every later launch is r0 / r1, once per DIVIDE visit.
  assign w_div_start    = (r_state == S_REDUCE) || ((r_state == S_DIVIDE) && !r_launched);
  assign w_div_dividend = (r_state == S_REDUCE) ? r_a : r_r0;
  assign w_div_divisor  = (r_state == S_REDUCE) ? r_m : r_r1;

  mod_divider #(.WIDTH(WIDTH)) u_div (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (w_div_start),
    .dividend_in   (w_div_dividend),
    .divisor_in    (w_div_divisor),
    .quotient_out  (w_div_q),
    .remainder_out (w_div_r),
    .done_out      (w_div_done)
  );

  // t1' = t0 - q*t1 at full product width, then cut back to WIDTH+1.
  assign w_q_ext  = {{(WIDTH+1){1'b0}}, w_div_q};
  assign w_t0_ext = {{WIDTH{r_t0[WIDTH]}}, r_t0};
  assign w_t1_ext = {{WIDTH{r_t1[WIDTH]}}, r_t1};
  assign w_prod   = w_q_ext * w_t1_ext;
  assign w_tdiff  = w_t0_ext - w_prod;
  assign w_t_new  = w_tdiff[WIDTH:0];
  assign w_t0_adj = r_t0[WIDTH] ? (r_t0 + $signed({1'b0, r_m})) : r_t0;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ready_in) w_next = S_CHECK;
        else          w_next = S_IDLE;
      end
      S_CHECK: begin
        if (w_m_small) w_next = S_DONE;
        else           w_next = S_REDUCE;
      end
      S_REDUCE: w_next = S_DIVIDE;
      S_DIVIDE: begin
        if (r_launched && w_div_done) w_next = S_UPDATE;
        else                          w_next = S_DIVIDE;
      end
      S_UPDATE: begin
        if (w_div_r == {WIDTH{1'b0}}) w_next = S_FINAL;
        else                          w_next = S_DIVIDE;
      end
      S_FINAL: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. CHECK seeds (r1,t0,t1) = (m,1,0) so the a/m reduction is retired by an ordinary
  // UPDATE, which leaves (r0,r1,t0,t1) = (m, a mod m, 0, 1).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_a          <= {WIDTH{1'b0}};
      r_m          <= {WIDTH{1'b0}};
      r_r0         <= {WIDTH{1'b0}};
      r_r1         <= {WIDTH{1'b0}};
      r_t0         <= {(WIDTH+1){1'b0}};
      r_t1         <= {(WIDTH+1){1'b0}};
      r_launched   <= 1'b0;
      r_res        <= {WIDTH{1'b0}};
      r_exists     <= 1'b0;
      r_value      <= {WIDTH{1'b0}};
      r_exists_out <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
`ifdef MODINV_STATS_EN
      r_iter       <= {ITER_CNT_W{1'b0}};
      r_iter_out   <= {ITER_CNT_W{1'b0}};
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ready_in) begin
            r_a    <= value_in;
            r_m    <= modulus_in;
            r_busy <= 1'b1;
          end
        end
        S_CHECK: begin
          r_r0       <= r_a;
          r_r1       <= r_m;
          r_t0       <= {{WIDTH{1'b0}}, 1'b1};
          r_t1       <= {(WIDTH+1){1'b0}};
          r_launched <= 1'b0;
          r_res      <= {WIDTH{1'b0}};
          r_exists   <= 1'b0;
`ifdef MODINV_STATS_EN
          r_iter     <= {ITER_CNT_W{1'b0}};
`endif
        end
        S_REDUCE: r_launched <= 1'b1;
        S_DIVIDE: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
`ifdef MODINV_STATS_EN
            r_iter     <= sat_inc(r_iter);
`endif
          end
        end
        S_UPDATE: begin
          r_r0       <= r_r1;
          r_r1       <= w_div_r;
          r_t0       <= r_t1;
          r_t1       <= w_t_new;
          r_launched <= 1'b0;
        end
        S_FINAL: begin
          if (r_r0 == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            r_exists <= 1'b1;
            r_res    <= w_t0_adj[WIDTH-1:0];
          end else begin
            r_exists <= 1'b0;
            r_res    <= {WIDTH{1'b0}};
          end
        end
        S_DONE: begin
          r_value      <= r_res;
          r_exists_out <= r_exists;
          r_valid      <= 1'b1;
          r_busy       <= 1'b0;
`ifdef MODINV_STATS_EN
          r_iter_out   <= r_iter;
`endif
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign value_out  = r_value;
  assign exists_out = r_exists_out;
  assign busy_out   = r_busy;
  assign valid_out  = r_valid;
`ifdef MODINV_STATS_EN
  assign iter_count_out = r_iter_out;
`endif

endmodule
